afe_inj_scan_ctrl: RTL and testbench

Injection-scan sequencer for the analog front end, clocked from the board oscillator inside the CPLD. It generates a programmable train of injection pulses toward the AFE charge-injection input. For every pulse it measures comparator time-over-threshold (TOT) and whether a hit occurred. Hit count and TOT statistics are accumulated for readback over the SPI register path, replacing manual per-pulse injection from the host.

---
 rtl/afe_pkg.sv | 15 +
 rtl/afe_inj_scan_ctrl_if.sv | 31 +++
 rtl/afe_sync2.sv | 23 ++
 rtl/afe_inj_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_afe_inj_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/afe_pkg.sv
// Shared types and default widths for the AFE injection-scan logic.
package afe_pkg;

    localparam int AFE_TOT_W       = 8;
    localparam int AFE_N_W         = 8;
    localparam int AFE_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        FIN
    } inj_state_t;

endpackage

// File: rtl/afe_inj_scan_ctrl_if.sv
// Control, configuration and result bundle between the SPI register path and the scan sequencer.
interface afe_inj_scan_ctrl_if
    import afe_pkg::*;
#(
    parameter int TOT_W = AFE_TOT_W,
    parameter int N_W   = AFE_N_W
);
    logic               START;
    logic               ABORT;
    logic [N_W-1:0]     N_INJ;
    logic [N_W-1:0]     T_HIGH;
    logic [N_W-1:0]     T_LOW;
    logic               COMP;
    logic               INJ;
    logic               BUSY;
    logic               DONE;
    logic [N_W-1:0]     HIT_CNT;
    logic [TOT_W-1:0]   TOT_LAST;
    logic [2*TOT_W-1:0] TOT_SUM;

    modport master (
        output START, ABORT, N_INJ, T_HIGH, T_LOW, COMP,
        input  INJ, BUSY, DONE, HIT_CNT, TOT_LAST, TOT_SUM
    );

    modport slave (
        input  START, ABORT, N_INJ, T_HIGH, T_LOW, COMP,
        output INJ, BUSY, DONE, HIT_CNT, TOT_LAST, TOT_SUM
    );

endinterface

// File: rtl/afe_sync2.sv
// Two-flop synchronizer for asynchronous AFE status lines; reset clears every stage.
module afe_sync2
    import afe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [AFE_SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[AFE_SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[AFE_SYNC_STAGES-1];

endmodule

// File: rtl/afe_inj_scan_ctrl.sv
// Injection-scan sequencer: emits an INJ pulse train and accumulates comparator TOT / hit statistics.
// States: IDLE wait for START | HIGH INJ driven high | LOW INJ low, TOT tail window | FIN one-cycle DONE
module afe_inj_scan_ctrl
    import afe_pkg::*;
#(
    parameter int TOT_W = AFE_TOT_W,
    parameter int N_W   = AFE_N_W
) (
    input logic                CLK,
    input logic                RST,
    afe_inj_scan_ctrl_if.slave bus
);

    localparam int SUM_W = 2 * TOT_W;

    inj_state_t       state, state_nxt;
    logic             comp_s;
    logic [N_W-1:0]   n_reg, h_reg, l_reg;
    logic [N_W-1:0]   pulse_cnt, phase_cnt, hit_cnt;
    logic [1:0]       tail_cnt;
    logic [TOT_W-1:0] tot, tot_inc, tot_last;
    logic [SUM_W-1:0] tot_sum;
    logic [SUM_W:0]   sum_wide;
    logic             inj, busy, done;
    logic             start_ok, count_en, phase_end, last_pulse;

    function automatic logic [N_W-1:0] phase_load(input logic [N_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    afe_sync2 u_comp_sync (
        .clk (CLK),
        .rst (RST),
        .d   (bus.COMP),
        .q   (comp_s)
    );

    assign start_ok   = (state == IDLE) && bus.START && !bus.ABORT;
    assign phase_end  = (phase_cnt == '0);
    assign last_pulse = (pulse_cnt == n_reg - 1'b1);
    // The first two LOW cycles still count, covering the synchronizer delay.
    assign count_en   = (state == HIGH) || ((state == LOW) && (tail_cnt != 2'd0));
    assign tot_inc    = (count_en && comp_s && (tot != '1)) ? tot + 1'b1 : tot;
    assign sum_wide   = {1'b0, tot_sum} + {{(SUM_W + 1 - TOT_W){1'b0}}, tot_inc};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.START) state_nxt = (bus.N_INJ == '0) ? FIN : HIGH;
            HIGH:    if (phase_end) state_nxt = LOW;
            LOW:     if (phase_end) state_nxt = last_pulse ? FIN : HIGH;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.ABORT) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            inj       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            n_reg     <= '0;
            h_reg     <= '0;
            l_reg     <= '0;
            pulse_cnt <= '0;
            phase_cnt <= '0;
            tail_cnt  <= '0;
            tot       <= '0;
            tot_last  <= '0;
            tot_sum   <= '0;
            hit_cnt   <= '0;
        end else begin
            inj  <= (state_nxt == HIGH);
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == FIN);
            tot  <= tot_inc;

            if ((state_nxt == HIGH) && (state != HIGH)) begin
                phase_cnt <= (state == IDLE) ? phase_load(bus.T_HIGH) : phase_load(h_reg);
                tot       <= '0;
            end else if ((state_nxt == LOW) && (state == HIGH)) begin
                phase_cnt <= phase_load(l_reg);
                tail_cnt  <= 2'd2;
            end else begin
                if (!phase_end) phase_cnt <= phase_cnt - 1'b1;
                if (tail_cnt != 2'd0) tail_cnt <= tail_cnt - 1'b1;
            end

            if (start_ok) begin
                n_reg     <= bus.N_INJ;
                h_reg     <= bus.T_HIGH;
                l_reg     <= bus.T_LOW;
                pulse_cnt <= '0;
                hit_cnt   <= '0;
                tot_last  <= '0;
                tot_sum   <= '0;
            end else if ((state == LOW) && phase_end && !bus.ABORT) begin
                tot_last  <= tot_inc;
                tot_sum   <= sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
                pulse_cnt <= pulse_cnt + 1'b1;
                if (tot_inc != '0) hit_cnt <= hit_cnt + 1'b1;
            end
        end
    end

    assign bus.INJ      = inj;
    assign bus.BUSY     = busy;
    assign bus.DONE     = done;
    assign bus.HIT_CNT  = hit_cnt;
    assign bus.TOT_LAST = tot_last;
    assign bus.TOT_SUM  = tot_sum;

endmodule

// File: tb/tb_afe_inj_scan_ctrl.sv
// Bench for afe_inj_scan_ctrl: table of scans plus abort / reset sequences against a pulse-window model.
module tb_afe_inj_scan_ctrl;

    localparam int TW      = 8;
    localparam int NW      = 8;
    localparam int TOT_MAX = (1 << TW) - 1;
    localparam int SUM_MAX = (1 << (2 * TW)) - 1;

    typedef struct {
        int n;
        int th;
        int tl;
        int mode;
        int mid_start;
        int exp_hit;
        int exp_last;
        int exp_sum;
        int exp_done;
    } vec_t;

    logic clk;
    logic rst;

    afe_inj_scan_ctrl_if #(.TOT_W(TW), .N_W(NW)) bus ();

    afe_inj_scan_ctrl #(.TOT_W(TW), .N_W(NW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   comp_at[int];
    vec_t vecs[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // COMP is only changed 1 time unit after an edge, so the value seen here is what the DUT sampled.
    task automatic tick();
        @(posedge clk);
        cyc++;
        comp_at[cyc] = bus.COMP;
        #1;
    endtask

    function automatic logic comp_fn(input int mode, input int rel, input int p);
        logic v;
        case (mode)
            0:       v = 1'b0;
            1:       v = 1'b1;
            2:       v = ((rel % p) >= 3) && ((rel % p) < 7);
            default: v = ($urandom_range(0, 3) == 0);
        endcase
        return v;
    endfunction

    // Pulse k is measured over the COMP values sampled from one edge before its INJ rise,
    // for H + min(L,2) consecutive edges.
    function automatic void model(input int t, input int n, input int h, input int l,
                                  output int hit, output int last, output int sum);
        int p;
        int w;
        int cnt;
        int tot;
        p    = h + l;
        w    = h + ((l < 2) ? l : 2);
        hit  = 0;
        last = 0;
        sum  = 0;
        for (int k = 0; k < n; k++) begin
            cnt = 0;
            for (int j = 0; j < w; j++) begin
                if (comp_at.exists(t + k * p - 1 + j) && comp_at[t + k * p - 1 + j]) cnt++;
            end
            tot  = (cnt > TOT_MAX) ? TOT_MAX : cnt;
            last = tot;
            sum  = (sum + tot > SUM_MAX) ? SUM_MAX : sum + tot;
            if (tot != 0) hit++;
        end
    endfunction

    task automatic start_scan(input int n, input int th, input int tl, input int mode, output int t);
        int p;
        p = ((th == 0) ? 1 : th) + ((tl == 0) ? 1 : tl);
        bus.N_INJ  = NW'(n);
        bus.T_HIGH = NW'(th);
        bus.T_LOW  = NW'(tl);
        bus.START  = 1'b1;
        t = cyc + 1;
        bus.COMP = comp_fn(mode, 0, p);
        tick();
        bus.START  = 1'b0;
        bus.N_INJ  = NW'($urandom);
        bus.T_HIGH = NW'($urandom);
        bus.T_LOW  = NW'($urandom);
    endtask

    task automatic idle(input int k);
        bus.COMP = 1'b0;
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " inj"},      longint'(bus.INJ), 0);
        check({tag, " busy"},     longint'(bus.BUSY), 0);
        check({tag, " done"},     longint'(bus.DONE), 0);
        check({tag, " hit_cnt"},  longint'(bus.HIT_CNT), 0);
        check({tag, " tot_last"}, longint'(bus.TOT_LAST), 0);
        check({tag, " tot_sum"},  longint'(bus.TOT_SUM), 0);
    endtask

    task automatic run_scan(input vec_t v, input int idx);
        int    h, l, p, total, t, rel;
        int    first_done, done_cnt, err_inj, err_busy;
        int    m_hit, m_last, m_sum;
        bit    exp_inj, exp_busy;
        string tag;
        tag   = $sformatf("scan%0d", idx);
        h     = (v.th == 0) ? 1 : v.th;
        l     = (v.tl == 0) ? 1 : v.tl;
        p     = h + l;
        total = v.n * p;
        m_hit = 0; m_last = 0; m_sum = 0;
        first_done = -1; done_cnt = 0; err_inj = 0; err_busy = 0;
        start_scan(v.n, v.th, v.tl, v.mode, t);
        for (int e = t; e <= t + total + 1; e++) begin
            rel      = e - t;
            exp_inj  = (v.n > 0) && (rel < total) && ((rel % p) < h);
            exp_busy = (rel <= total);
            if (bus.INJ !== exp_inj) err_inj++;
            if (bus.BUSY !== exp_busy) err_busy++;
            if (bus.DONE === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = rel + 1;
            end
            if (rel == total) begin
                model(t, v.n, h, l, m_hit, m_last, m_sum);
                check({tag, " hit_cnt"},  longint'(bus.HIT_CNT), m_hit);
                check({tag, " tot_last"}, longint'(bus.TOT_LAST), m_last);
                check({tag, " tot_sum"},  longint'(bus.TOT_SUM), m_sum);
                if (v.exp_hit >= 0) begin
                    check({tag, " hit_cnt table"},  longint'(bus.HIT_CNT), v.exp_hit);
                    check({tag, " tot_last table"}, longint'(bus.TOT_LAST), v.exp_last);
                    check({tag, " tot_sum table"},  longint'(bus.TOT_SUM), v.exp_sum);
                end
            end
            if (e == t + total + 1) break;
            bus.START = (v.mid_start != 0) && (rel == 1);
            bus.COMP  = comp_fn(v.mode, rel + 1, p);
            tick();
        end
        bus.START = 1'b0;
        check({tag, " inj wave errors"},  err_inj, 0);
        check({tag, " busy wave errors"}, err_busy, 0);
        check({tag, " done pulses"},      done_cnt, 1);
        check({tag, " done cycle"},       first_done, total + 1);
        if (v.exp_done >= 0) check({tag, " done cycle table"}, first_done, v.exp_done);
        idle(3);
        check({tag, " hold hit_cnt"}, longint'(bus.HIT_CNT), m_hit);
        check({tag, " hold tot_sum"}, longint'(bus.TOT_SUM), m_sum);
    endtask

    initial begin
        int t;
        int dcount;
        vec_t vr;

        rst        = 1'b1;
        bus.START  = 1'b0;
        bus.ABORT  = 1'b0;
        bus.N_INJ  = '0;
        bus.T_HIGH = '0;
        bus.T_LOW  = '0;
        bus.COMP   = 1'b0;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        idle(2);

        //              n   th   tl mode mid  hit last  sum done
        vecs.push_back('{3, 10,   5,  2,  0,   3,   4,  12,  46});
        vecs.push_back('{5,  4,   3,  0,  0,   0,   0,   0,  36});
        vecs.push_back('{2, 255, 10,  1,  0,   2, 255, 510, 531});
        vecs.push_back('{0,  5,   5,  1,  0,   0,   0,   0,   1});
        vecs.push_back('{2,  0,   0,  1,  0,   2,   2,   3,   5});
        vecs.push_back('{3,  4,   2,  2,  1,  -1,  -1,  -1,  -1});
        for (int i = 0; i < 8; i++) begin
            vr = '{$urandom_range(0, 6), $urandom_range(0, 20), $urandom_range(0, 8), 3,
                   $urandom_range(0, 1), -1, -1, -1, -1};
            vecs.push_back(vr);
        end
        foreach (vecs[i]) run_scan(vecs[i], i);

        // ABORT in the high phase of the second pulse.
        start_scan(4, 6, 4, 2, t);
        while (cyc < t + 12) begin
            bus.COMP = comp_fn(2, cyc + 1 - t, 10);
            tick();
        end
        check("abort pre inj", longint'(bus.INJ), 1);
        bus.ABORT = 1'b1;
        tick();
        check("abort inj",      longint'(bus.INJ), 0);
        check("abort busy",     longint'(bus.BUSY), 0);
        check("abort done",     longint'(bus.DONE), 0);
        check("abort hit_cnt",  longint'(bus.HIT_CNT), 1);
        check("abort tot_last", longint'(bus.TOT_LAST), 4);
        check("abort tot_sum",  longint'(bus.TOT_SUM), 4);
        bus.START = 1'b1;
        tick();
        check("abort beats start", longint'(bus.BUSY), 0);
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.DONE === 1'b1) dcount++;
        end
        check("abort no done", dcount, 0);
        check("abort retained hit_cnt", longint'(bus.HIT_CNT), 1);

        // RST during the high phase of the second pulse.
        start_scan(3, 8, 3, 1, t);
        while (cyc < t + 13) begin
            bus.COMP = 1'b1;
            tick();
        end
        check("rst pre inj", longint'(bus.INJ), 1);
        check("rst pre hit_cnt", longint'(bus.HIT_CNT), 1);
        bus.COMP = 1'b0;
        rst = 1'b1;
        tick();
        check_zero_outputs("mid rst");
        rst = 1'b0;
        idle(2);
        vr = '{2, 3, 2, 1, 0, 2, 5, 9, 11};
        run_scan(vr, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
